// File: rtl/mc_def.sv
// mc_def: shared state encodings, opcode/funct constants and ALU operations for mips_multicycle.
package mc_def;
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_LUI} alu_op_e;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    // sll shifts b by a[4:0]; lui passes the pre-shifted immediate on b
    function automatic logic [31:0] alu(input alu_op_e f, input logic [31:0] a, input logic [31:0] b);
        return f == ALU_SUB ? a - b :
               f == ALU_AND ? a & b :
               f == ALU_OR  ? a | b :
               f == ALU_SLT ? {31'b0, $signed(a) < $signed(b)} :
               f == ALU_SLL ? b << a[4:0] :
               f == ALU_LUI ? b : a + b;
    endfunction
endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 32x32 register file, two async read ports, one sync write port, r0 reads 0.
module mc_regfile (
    input  logic        clk,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] regs_q [32];

    always_ff @(posedge clk)
        if (we_i && wa_i != 5'd0) regs_q[wa_i] <= wd_i;

    assign rd1_o = ra1_i == 5'd0 ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = ra2_i == 5'd0 ? 32'd0 : regs_q[ra2_i];
endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle MIPS-I subset core sharing one req/ready memory port.
// Defining MIPS_MC_TRAP_EN adds a TRAP state for unknown instructions and misaligned lw/sw.
module mips_multicycle
    import mc_def::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          AW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ready,
    output logic [31:0]   pc_o,
    output logic [2:0]    state_o,
    output logic          halted
);
    state_e      state_q, state_d;
    alu_op_e     alu_op;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [31:0] rs_val, rt_val, wb_data, imm_s, op_a, op_b, alu_y;
    logic [5:0]  op, fn;
    logic [4:0]  wb_addr;
    logic        wb_en, known, is_r;

    assign op    = ir_q[31:26];
    assign fn    = ir_q[5:0];
    assign is_r  = op == OP_R;
    assign imm_s = {{16{ir_q[15]}}, ir_q[15:0]};
    assign known = is_r ? fn inside {FN_SLL, FN_JR, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT}
                        : op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW};

    assign alu_op = is_r ? (fn == FN_SUBU ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
                            fn == FN_SLT ? ALU_SLT : fn == FN_SLL ? ALU_SLL : ALU_ADD)
                         : (op == OP_ORI ? ALU_OR : op == OP_LUI ? ALU_LUI : ALU_ADD);
    assign op_a  = is_r && fn == FN_SLL ? {27'b0, ir_q[10:6]} : a_q;
    assign op_b  = is_r ? b_q : op == OP_ORI ? {16'b0, ir_q[15:0]} : op == OP_LUI ? {ir_q[15:0], 16'b0} : imm_s;
    assign alu_y = alu(alu_op, op_a, op_b);

    // jal links in DECODE; everything else writes back in WB
    assign wb_en   = (state_q == S_DECODE && op == OP_JAL) || state_q == S_WB;
    assign wb_addr = state_q == S_DECODE ? 5'd31 : is_r ? ir_q[15:11] : ir_q[20:16];
    assign wb_data = state_q == S_DECODE ? pc_q : op == OP_LW ? mdr_q : alu_q;

    mc_regfile u_rf (
        .clk   (clk),
        .ra1_i (ir_q[25:21]),
        .ra2_i (ir_q[20:16]),
        .we_i  (wb_en),
        .wa_i  (wb_addr),
        .wd_i  (wb_data),
        .rd1_o (rs_val),
        .rd2_o (rt_val)
    );

    assign mem_req   = !rst && (state_q == S_FETCH || state_q == S_MEM);
    assign mem_we    = !rst && state_q == S_MEM && op == OP_SW;
    assign mem_addr  = state_q == S_FETCH ? {pc_q[AW-1:2], 2'b00} : {alu_q[AW-1:2], 2'b00};
    assign mem_wdata = b_q;
    assign pc_o      = pc_q;
    assign state_o   = state_q;
`ifdef MIPS_MC_TRAP_EN
    assign halted    = state_q == S_TRAP;
`else
    assign halted    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        case (state_q)
            S_FETCH: if (mem_ready) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 32'd4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = rs_val;
                b_d     = rt_val;
                state_d = S_EXEC;
                if (op == OP_J || op == OP_JAL) begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    state_d = S_FETCH;
                end else if (is_r && fn == FN_JR) begin
                    pc_d    = rs_val;
                    state_d = S_FETCH;
                end else if (!known) begin
`ifdef MIPS_MC_TRAP_EN
                    pc_d    = pc_q - 32'd4;
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_d   = alu_y;
                state_d = S_WB;
                if (op == OP_BEQ || op == OP_BNE) begin
                    state_d = S_FETCH;
                    if ((a_q == b_q) == (op == OP_BEQ)) pc_d = pc_q + {imm_s[29:0], 2'b00};
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEM;
`ifdef MIPS_MC_TRAP_EN
                    if (alu_y[1:0] != 2'b00) begin
                        pc_d    = pc_q - 32'd4;
                        state_d = S_TRAP;
                    end
`endif
                end
            end
            S_MEM: if (mem_ready) begin
                mdr_d   = mem_rdata;
                state_d = op == OP_LW ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end
endmodule
